// File: rtl/jk_flag_sequencer.sv
// jk_flag_sequencer
//
// Shared controller for a bank of external JK flip-flop status flags.
// Requesters issue read/set/clear/toggle commands; a round-robin arbiter
// picks one, the block drives that flag's J/K for exactly one clock, then
// samples the flag's Q, returns it and checks it against the expected value.
//
// Handshake: a requester raises req and holds op/idx stable until the grant
// edge; gnt marks the owner while its operation is in flight; done pulses
// for one cycle with err/rdata valid. op/idx are sampled only at the grant
// edge, and dropping req after the grant does not cancel the operation.
//
// Ports:
//   clk    - clock, all state changes on posedge (flag cells share it)
//   rst    - synchronous active-high reset
//   req    - per-requester request level
//   op     - per-requester opcode, 2 bits each: 00 read, 01 set, 10 clear, 11 toggle
//   idx    - per-requester flag index, IDXW bits each
//   gnt    - one-hot grant, high while the owner's operation is in flight
//   done   - one-cycle completion pulse
//   err    - with done: bad index or readback mismatch
//   rdata  - with done: flag Q after the operation
//   j_out  - J drive to each flag cell
//   k_out  - K drive to each flag cell
//   q_in   - Q from each flag cell
module jk_flag_sequencer #(
    parameter int NREQ   = 3,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic                 err,
    output logic                 rdata,
    output logic [NFLAGS-1:0]    j_out,
    output logic [NFLAGS-1:0]    k_out,
    input  logic [NFLAGS-1:0]    q_in
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]   gnt_n;
    logic              done_n, err_n, rdata_n;
    logic [NFLAGS-1:0] j_n, k_n;
    logic [1:0]        cur_op, op_n;
    logic [IDXW-1:0]   cur_idx, idx_n;
    logic              old_q, old_n;
    // Owner acknowledged on the previous edge; masked for exactly the done cycle.
    logic [NREQ-1:0]   ack_mask, ack_n;

    // Round-robin search starting at ptr.
    logic [NREQ-1:0]   elig;
    logic              found;
    logic [PW-1:0]     win;
    logic [1:0]        win_op;
    logic [IDXW-1:0]   win_idx;
    int                arb_c;

    always_comb begin
        elig    = req & ~ack_mask;
        found   = 1'b0;
        win     = '0;
        win_op  = '0;
        win_idx = '0;
        arb_c   = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_c = (int'(ptr) + k) % NREQ;
            if (!found && elig[arb_c]) begin
                found   = 1'b1;
                win     = PW'(arb_c);
                win_op  = op[2*arb_c +: 2];
                win_idx = idx[IDXW*arb_c +: IDXW];
            end
        end
    end

    // Q of the latched flag; out-of-range indices read as 0 and never match.
    logic idx_ok;
    logic q_sel;
    logic expected;

    always_comb begin
        idx_ok = (int'(cur_idx) < NFLAGS);
        q_sel  = 1'b0;
        for (int f = 0; f < NFLAGS; f++) begin
            if (int'(cur_idx) == f) q_sel = q_in[f];
        end
        case (cur_op)
            2'b00:   expected = old_q;
            2'b01:   expected = 1'b1;
            2'b10:   expected = 1'b0;
            default: expected = ~old_q;
        endcase
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdata_n = 1'b0;
        j_n     = '0;
        k_n     = '0;
        op_n    = cur_op;
        idx_n   = cur_idx;
        old_n   = old_q;
        ack_n   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = DRIVE;
                    op_n    = win_op;
                    idx_n   = win_idx;
                    gnt_n   = NREQ'(1) << win;
                    ptr_n   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    // op[0] maps to J and op[1] to K for all four opcodes.
                    for (int f = 0; f < NFLAGS; f++) begin
                        if (int'(win_idx) == f) begin
                            j_n[f] = win_op[0];
                            k_n[f] = win_op[1];
                        end
                    end
                end
            end
            DRIVE: begin
                // The cell captures J/K on this edge, so q_in is still the old value.
                old_n   = q_sel;
                state_n = SAMPLE;
            end
            SAMPLE: begin
                rdata_n = idx_ok ? q_sel : 1'b0;
                err_n   = idx_ok ? (q_sel != expected) : 1'b1;
                done_n  = 1'b1;
                ack_n   = gnt;
                gnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 1'b0;
            j_out    <= '0;
            k_out    <= '0;
            cur_op   <= '0;
            cur_idx  <= '0;
            old_q    <= 1'b0;
            ack_mask <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            done     <= done_n;
            err      <= err_n;
            rdata    <= rdata_n;
            j_out    <= j_n;
            k_out    <= k_n;
            cur_op   <= op_n;
            cur_idx  <= idx_n;
            old_q    <= old_n;
            ack_mask <= ack_n;
        end
    end

endmodule

// File: tb/tb_jk_flag_sequencer.sv
// Testbench for jk_flag_sequencer with NREQ=3, NFLAGS=6, IDXW=3.
// Models the external JK flag cells (no reset), with an optional stuck-at-0
// fault on flag 5.
module tb_jk_flag_sequencer;

    localparam int NREQ   = 3;
    localparam int NFLAGS = 6;
    localparam int IDXW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [IDXW*NREQ-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic                 done, err, rdata;
    logic [NFLAGS-1:0]    j_out, k_out, q_in;

    jk_flag_sequencer #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .j_out(j_out), .k_out(k_out), .q_in(q_in)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- flag cell model ----------------
    logic [NFLAGS-1:0] flags = '0;
    logic              stuck5 = 1'b0;

    always @(posedge clk) begin
        for (int f = 0; f < NFLAGS; f++) begin
            case ({j_out[f], k_out[f]})
                2'b10:   flags[f] <= 1'b1;
                2'b01:   flags[f] <= 1'b0;
                2'b11:   flags[f] <= ~flags[f];
                default: ;
            endcase
        end
    end

    assign q_in = flags & ~(stuck5 ? 6'b100000 : 6'b000000);

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];   // {err, rdata}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [1:0] e;
            chk("jk_one_pair", 32'($countones(j_out | k_out) <= 1), 32'd1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", {30'b0, err, rdata}, {30'b0, e});
                end
            end else begin
                chk("idle_err_rdata", {30'b0, err, rdata}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [NFLAGS-1:0] drv_bit(input logic b, input logic [2:0] ix);
        logic [NFLAGS-1:0] v;
        v = '0;
        if (int'(ix) < NFLAGS) v[ix] = b;
        return v;
    endfunction

    task automatic single_op(input int r, input logic [1:0] o, input logic [2:0] ix,
                             input logic exp_rd, input logic exp_er);
        logic [NREQ-1:0] g;
        g = '0;
        g[r] = 1'b1;
        @(negedge clk);
        req[r]            = 1'b1;
        op[2*r +: 2]      = o;
        idx[IDXW*r +: IDXW] = ix;
        @(posedge clk); #1;            // DRIVE cycle
        chk("drive_gnt", 32'(gnt), 32'(g));
        chk("drive_j", 32'(j_out), 32'(drv_bit(o[0], ix)));
        chk("drive_k", 32'(k_out), 32'(drv_bit(o[1], ix)));
        exp_q.push_back({exp_er, exp_rd});
        @(posedge clk); #1;            // SAMPLE cycle
        chk("sample_gnt", 32'(gnt), 32'(g));
        chk("sample_jk", 32'({j_out, k_out}), 32'd0);
        chk("sample_done", 32'(done), 32'd0);
        @(posedge clk); #1;            // done cycle
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        req[r] = 1'b0;
    endtask

    typedef struct {
        int         r;
        logic [1:0] o;
        logic [2:0] ix;
        logic       rd;
        logic       er;
    } vec_t;

    vec_t vecs[10];
    int   gcount[NREQ];

    initial begin
        vecs[0] = '{0, 2'b01, 3'd5, 1'b1, 1'b0};  // set 5
        vecs[1] = '{0, 2'b11, 3'd5, 1'b0, 1'b0};  // toggle 5 -> 0
        vecs[2] = '{1, 2'b01, 3'd3, 1'b1, 1'b0};  // set 3
        vecs[3] = '{2, 2'b00, 3'd3, 1'b1, 1'b0};  // read 3
        vecs[4] = '{1, 2'b01, 3'd7, 1'b0, 1'b1};  // bad index 7
        vecs[5] = '{2, 2'b10, 3'd3, 1'b0, 1'b0};  // clear 3
        vecs[6] = '{0, 2'b11, 3'd0, 1'b1, 1'b0};  // toggle 0 -> 1
        vecs[7] = '{1, 2'b00, 3'd0, 1'b1, 1'b0};  // read 0
        vecs[8] = '{2, 2'b11, 3'd0, 1'b0, 1'b0};  // toggle 0 -> 0
        vecs[9] = '{0, 2'b11, 3'd6, 1'b0, 1'b1};  // bad index 6

        rst = 1'b1;
        req = '0;
        op  = '0;
        idx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done_err_rdata", {29'b0, done, err, rdata}, 32'd0);
        chk("rst_jk", 32'({j_out, k_out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            single_op(vecs[i].r, vecs[i].o, vecs[i].ix, vecs[i].rd, vecs[i].er);

        // Stuck-at-0 Q on flag 5: set must report mismatch.
        stuck5 = 1'b1;
        single_op(1, 2'b01, 3'd5, 1'b0, 1'b1);
        stuck5 = 1'b0;
        single_op(2, 2'b00, 3'd5, 1'b1, 1'b0);   // cell did capture the set

        // Reset to bring ptr back to 0, then all three requesters clear 0,1,2.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;
        req = 3'b111;
        op  = 6'b10_10_10;
        idx = {3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 6; k++) begin
            logic [NREQ-1:0] g;
            g = '0;
            g[k % NREQ] = 1'b1;
            @(posedge clk); #1;
            chk("rr_gnt", 32'(gnt), 32'(g));
            for (int i = 0; i < NREQ; i++) gcount[i] += int'(gnt[i]);
            exp_q.push_back(2'b00);
            @(posedge clk);
            @(posedge clk); #1;
            chk("rr_done_pulse", 32'(done), 32'd1);
        end
        @(negedge clk);
        req = '0;
        for (int i = 0; i < NREQ; i++) chk("rr_fair_count", 32'(gcount[i]), 32'd2);

        // Reset during DRIVE of a toggle on flag 2 (currently 0).
        @(negedge clk);
        req[0]   = 1'b1;
        op[1:0]  = 2'b11;
        idx[2:0] = 3'd2;
        @(posedge clk); #1;
        chk("mid_drive_j", 32'(j_out), 32'h04);
        chk("mid_drive_k", 32'(k_out), 32'h04);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_outs", {29'b0, done, err, rdata}, 32'd0);
        chk("mid_rst_jk", 32'({j_out, k_out}), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        req[0] = 1'b0;
        repeat (4) @(posedge clk);
        single_op(0, 2'b00, 3'd2, 1'b1, 1'b0);   // toggle captured at reset edge

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_flag_sequencer.md
# jk_flag_sequencer

Shared controller for a bank of external JK flip-flop status flags. Accepts set/clear/toggle/read commands from several requesters, arbitrates round-robin and drives each flag's J/K inputs for exactly one clock. It then samples the flag's Q, returns the result and checks it against the expected value. Sits between the control sequencer and the flag cells; the cells themselves have no reset and are only ever written through this block.

## Interface
Parameters:
- NREQ, 3, number of requesters
- NFLAGS, 8, number of JK flag cells controlled
- IDXW, 3, flag index width (2^IDXW >= NFLAGS)

Ports:
- clk  in  1  single clock, all state changes on posedge; flag cells share this clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; hold until done
- op  in  2*NREQ  per-requester opcode, slice [2i+1:2i]: 00 read, 01 set, 10 clear, 11 toggle
- idx  in  IDXW*NREQ  per-requester flag index, slice [IDXW*i+IDXW-1:IDXW*i]
- gnt  out  NREQ  one-hot grant, high while the owner's operation is in flight
- done  out  1  one-cycle completion pulse for the current grant owner
- err  out  1  valid with done: bad index or readback mismatch
- rdata  out  1  valid with done: flag Q after the operation
- j_out  out  NFLAGS  J drive to each flag cell
- k_out  out  NFLAGS  K drive to each flag cell
- q_in  in  NFLAGS  Q from each flag cell

## Operation
- States: IDLE, DRIVE, SAMPLE. All outputs are registered.
- IDLE: if any eligible req is high at the clock edge, pick the winner by searching from ptr upward, modulo NREQ.
  - Latch the winner's op and idx, set gnt[winner], set ptr = winner+1 mod NREQ, go to DRIVE.
  - On the same edge, load j_out/k_out for the latched flag: set → J=1,K=0; clear → J=0,K=1; toggle → J=1,K=1; read → both 0.
- DRIVE: the flag cell captures J/K at the edge leaving DRIVE.
  - On that edge, clear all j_out/k_out and capture old = q_in[idx], which is the pre-update value.
  - Go to SAMPLE.
- SAMPLE: at the edge leaving SAMPLE:
  - rdata = q_in[idx].
  - expected = 1 for set, 0 for clear, ~old for toggle, old for read.
  - err = (rdata != expected).
  - done = 1, gnt cleared, go to IDLE.
- Eligibility: in the cycle where done=1, the just-acknowledged requester is masked from arbitration. Other requesters may win on that same edge.
- Bad index (idx >= NFLAGS): no J/K is driven and the full DRIVE/SAMPLE sequence still runs. The result is done=1, err=1, rdata=0.
- At most one j_out/k_out pair is non-zero in any cycle. Both vectors are zero outside DRIVE.
- Dropping req mid-operation is ignored; the operation completes and done still pulses.
- op/idx are sampled only at the grant edge. Later changes have no effect.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, err=0, rdata=0, j_out=0, k_out=0.
- Reset mid-operation: everything returns to reset values on the next edge and no done is issued. A flag already clocked in DRIVE keeps its new value; nothing is rolled back.
- Latency: req high at edge E0 (IDLE) → gnt high E0..E2 → J/K high for one cycle after E0 → flag updates at E1 → done/err/rdata high for one cycle after E2.
- Throughput: one operation per 3 cycles under continuous requests.
- done, err and rdata are all valid in the same single cycle. err and rdata are 0 whenever done=0.
- Fairness: under continuous requests from all NREQ requesters, each requester is granted once every NREQ operations.

## Test plan
- Reset, then requester 0 sets flag 5: gnt=001 for 2 cycles, j_out=0x20 and k_out=0 for 1 cycle, then done=1, rdata=1, err=0. A following toggle on flag 5 gives rdata=0, err=0.
- All three requesters hold req with clear ops on flags 0,1,2: grants follow order 0,1,2,0,…; done pulses every 3 cycles; each requester is granted exactly once per 3 operations.
- Read flag 3 after a set: j_out=k_out=0 throughout; done with rdata=1, err=0; flag unchanged.
- idx=7 with NFLAGS=6: no J/K activity; done=1, err=1, rdata=0.
- Force the flag-5 cell Q stuck at 0, then set flag 5: done=1, rdata=0, err=1.
- Assert rst during the DRIVE cycle of a toggle on flag 2: next cycle all outputs are zero, no done occurs, and the flag reflects the toggle that was captured at the reset edge.
